stream_demux_1x2: RTL and testbench

Registered 1-to-2 stream demultiplexer with valid/ready handshakes. It is the fan-out counterpart of the 2:1 selection path: a single coefficient stream from the NTT butterfly datapath is steered by a per-word select bit into one of two downstream consumers, such as even/odd memory banks. Each branch has a 2-entry buffer, so one branch can stall without losing data and both branches sustain one word per cycle. No combinational path runs from any `out*_ready` to `in_ready`.

---
 rtl/stream_demux_1x2.sv | 122 ++++++++++++
 tb/tb_stream_demux_1x2.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1x2.sv
// Registered 1-to-2 stream demultiplexer: each branch has a 2-entry FIFO selected per word by in_sel.
// Optional delivery counters are built when STREAM_DEMUX_CNT_EN is defined; otherwise cnt_a/cnt_b read 0.
module stream_demux_1x2 #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in_data,
  input  logic         in_sel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] outa_data,
  output logic         outa_valid,
  input  logic         outa_ready,
  output logic [N-1:0] outb_data,
  output logic         outb_valid,
  input  logic         outb_ready,
  output logic [15:0]  cnt_a,
  output logic [15:0]  cnt_b
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  // A push while FULL or a pop while EMPTY cannot happen; those combinations hold state.
  function automatic occ_t next_occ(input occ_t cur, input logic push, input logic pop);
    occ_t nxt;
    nxt = cur;
    case (cur)
      EMPTY:   if (push) nxt = ONE;
      ONE:     if (push && !pop) nxt = FULL;
               else if (!push && pop) nxt = EMPTY;
      FULL:    if (pop) nxt = ONE;
      default: nxt = EMPTY;
    endcase
    return nxt;
  endfunction

  logic [N-1:0] mem_a [2];
  logic [N-1:0] mem_b [2];
  logic         wptr_a, rptr_a, wptr_b, rptr_b;
  occ_t         occ_a, occ_b;
  logic         full_a, full_b;
  logic         push_a, push_b, pop_a, pop_b;

  assign full_a = (occ_a == FULL);
  assign full_b = (occ_b == FULL);

  // in_ready is a function of registered occupancy and in_sel only, never of the out readies.
  assign in_ready = in_sel ? ~full_b : ~full_a;

  assign push_a = in_valid & in_ready & ~in_sel;
  assign push_b = in_valid & in_ready &  in_sel;
  assign pop_a  = outa_valid & outa_ready;
  assign pop_b  = outb_valid & outb_ready;

  assign outa_valid = (occ_a != EMPTY);
  assign outb_valid = (occ_b != EMPTY);
  assign outa_data  = mem_a[rptr_a];
  assign outb_data  = mem_b[rptr_b];

  // Branch A buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_a[0] <= '0;
      mem_a[1] <= '0;
      wptr_a   <= 1'b0;
      rptr_a   <= 1'b0;
      occ_a    <= EMPTY;
    end else begin
      if (push_a) begin
        mem_a[wptr_a] <= in_data;
        wptr_a        <= ~wptr_a;
      end
      if (pop_a) rptr_a <= ~rptr_a;
      occ_a <= next_occ(occ_a, push_a, pop_a);
    end
  end

  // Branch B buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_b[0] <= '0;
      mem_b[1] <= '0;
      wptr_b   <= 1'b0;
      rptr_b   <= 1'b0;
      occ_b    <= EMPTY;
    end else begin
      if (push_b) begin
        mem_b[wptr_b] <= in_data;
        wptr_b        <= ~wptr_b;
      end
      if (pop_b) rptr_b <= ~rptr_b;
      occ_b <= next_occ(occ_b, push_b, pop_b);
    end
  end

`ifdef STREAM_DEMUX_CNT_EN
  logic [15:0] cnt_a_q, cnt_b_q;

  // Free-running delivery counters, wrapping at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= 16'd0;
      cnt_b_q <= 16'd0;
    end else begin
      if (pop_a) cnt_a_q <= cnt_a_q + 16'd1;
      if (pop_b) cnt_b_q <= cnt_b_q + 16'd1;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`else
  assign cnt_a = 16'd0;
  assign cnt_b = 16'd0;
`endif

endmodule

// File: tb/tb_stream_demux_1x2.sv
// Self-checking bench for stream_demux_1x2: directed scenarios plus a queue-based randomized soak.
module tb_stream_demux_1x2;

  localparam int WORDS  = 10000;
  localparam int BUDGET = 40000;
`ifdef STREAM_DEMUX_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] outa_data, outb_data;
  logic        outa_valid, outb_valid;
  logic        outa_ready = 1'b0;
  logic        outb_ready = 1'b0;
  logic [15:0] cnt_a, cnt_b;

  int total = 0;
  int bad   = 0;

  stream_demux_1x2 #(.N(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .outa_data(outa_data), .outa_valid(outa_valid), .outa_ready(outa_ready),
    .outb_data(outb_data), .outb_valid(outb_valid), .outb_ready(outb_ready),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; outa_ready = 1'b0; outb_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (outa_valid !== 1'b0 || outb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got a=%b b=%b want 0 0", outa_valid, outb_valid); end
    // fill both branches with readies low
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sel = i[1]; in_data = 16'(i + 1);
    end
    @(negedge clk);
    in_valid = 1'b0; in_sel = 1'b0;
    #1;
    total++; if (outa_valid !== 1'b1 || outb_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL fill_full: got va=%b vb=%b rdy=%b want 1 1 0", outa_valid, outb_valid, in_ready); end
    total++; if (outa_data !== 16'h0001 || outb_data !== 16'h0003) begin bad++; $display("FAIL fill_heads: got a=%h b=%h want 0001 0003", outa_data, outb_data); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL async_rst_ready_a: got %b want 1", in_ready); end
    in_sel = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL async_rst_ready_b: got %b want 1", in_ready); end
    total++; if (outa_valid !== 1'b0 || outb_valid !== 1'b0) begin bad++; $display("FAIL async_rst_valid: got a=%b b=%b want 0 0", outa_valid, outb_valid); end
    total++; if (cnt_a !== 16'd0 || cnt_b !== 16'd0) begin bad++; $display("FAIL async_rst_cnt: got a=%0d b=%0d want 0 0", cnt_a, cnt_b); end
    total++; if (outa_data !== 16'd0 || outb_data !== 16'd0) begin bad++; $display("FAIL async_rst_data: got a=%h b=%h want 0 0", outa_data, outb_data); end
    @(negedge clk);
    rst_n = 1'b1; in_sel = 1'b0;
  endtask

  task automatic test_routing();
    do_reset();
    outa_ready = 1'b1; outb_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h0001;
    @(negedge clk);
    in_sel = 1'b1; in_data = 16'h0002;
    #1;
    total++; if (outa_valid !== 1'b1 || outa_data !== 16'h0001 || in_ready !== 1'b1) begin bad++; $display("FAIL route_w1: got va=%b a=%h rdy=%b want 1 0001 1", outa_valid, outa_data, in_ready); end
    @(negedge clk);
    in_sel = 1'b0; in_data = 16'h0003;
    #1;
    total++; if (outa_valid !== 1'b0 || outb_valid !== 1'b1 || outb_data !== 16'h0002 || in_ready !== 1'b1) begin bad++; $display("FAIL route_w2: got va=%b vb=%b b=%h rdy=%b want 0 1 0002 1", outa_valid, outb_valid, outb_data, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++; if (outa_valid !== 1'b1 || outa_data !== 16'h0003 || outb_valid !== 1'b0) begin bad++; $display("FAIL route_w3: got va=%b a=%h vb=%b want 1 0003 0", outa_valid, outa_data, outb_valid); end
    @(negedge clk);
    #1;
    total++; if (outa_valid !== 1'b0 || outb_valid !== 1'b0) begin bad++; $display("FAIL route_drain: got va=%b vb=%b want 0 0", outa_valid, outb_valid); end
  endtask

  task automatic test_stall();
    do_reset();
    outa_ready = 1'b0; outb_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h00A1;
    @(negedge clk);
    in_data = 16'h00A2;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_a2_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_data = 16'h00A3;
    #1;
    total++; if (in_ready !== 1'b0 || outa_data !== 16'h00A1) begin bad++; $display("FAIL stall_a3_block: got rdy=%b a=%h want 0 00a1", in_ready, outa_data); end
    @(negedge clk);
    in_sel = 1'b1; in_data = 16'h00B1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_b1_ready: got %b want 1", in_ready); end
    @(negedge clk);
    outa_ready = 1'b1; in_sel = 1'b0; in_data = 16'h00A3;
    #1;
    total++; if (outb_valid !== 1'b1 || outb_data !== 16'h00B1 || outa_data !== 16'h00A1 || in_ready !== 1'b0) begin bad++; $display("FAIL stall_release: got vb=%b b=%h a=%h rdy=%b want 1 00b1 00a1 0", outb_valid, outb_data, outa_data, in_ready); end
    @(negedge clk);
    #1;
    total++; if (outa_data !== 16'h00A2 || in_ready !== 1'b1 || outb_valid !== 1'b0) begin bad++; $display("FAIL stall_a2_out: got a=%h rdy=%b vb=%b want 00a2 1 0", outa_data, in_ready, outb_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++; if (outa_valid !== 1'b1 || outa_data !== 16'h00A3) begin bad++; $display("FAIL stall_a3_out: got va=%b a=%h want 1 00a3", outa_valid, outa_data); end
    @(negedge clk);
    #1;
    total++; if (outa_valid !== 1'b0) begin bad++; $display("FAIL stall_empty: got %b want 0", outa_valid); end
  endtask

  task automatic test_push_pop_one();
    do_reset();
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h0011;
    @(negedge clk);
    outa_ready = 1'b1; in_data = 16'h0022;
    #1;
    total++; if (outa_data !== 16'h0011 || outa_valid !== 1'b1) begin bad++; $display("FAIL pp_head0: got va=%b a=%h want 1 0011", outa_valid, outa_data); end
    @(negedge clk);
    outa_ready = 1'b0; in_data = 16'h0033;
    #1;
    total++; if (outa_data !== 16'h0022 || outa_valid !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL pp_head1: got va=%b a=%h rdy=%b want 1 0022 1", outa_valid, outa_data, in_ready); end
    @(negedge clk);
    in_valid = 1'b0; outa_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0 || outa_data !== 16'h0022) begin bad++; $display("FAIL pp_full: got rdy=%b a=%h want 0 0022", in_ready, outa_data); end
    @(negedge clk);
    #1;
    total++; if (outa_data !== 16'h0033 || outa_valid !== 1'b1) begin bad++; $display("FAIL pp_tail: got va=%b a=%h want 1 0033", outa_valid, outa_data); end
    @(negedge clk);
    outa_ready = 1'b0;
  endtask

  task automatic test_random_soak();
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    int  sent = 0, pops_a = 0, pops_b = 0, cyc = 0;
    bit  hold = 0, exp_rdy, do_push, do_pa, do_pb, ra, rb;
    do_reset();
    while (cyc < BUDGET && !(sent == WORDS && qa.size() == 0 && qb.size() == 0)) begin
      if (!hold) begin
        in_valid = (sent < WORDS) && ($urandom_range(3) != 0);
        in_sel   = 1'($urandom_range(1));
        in_data  = 16'($urandom);
      end
      ra = 1'($urandom_range(1)); rb = 1'($urandom_range(1));
      outa_ready = ra; outb_ready = rb;
      #1;
      exp_rdy = in_sel ? (qb.size() < 2) : (qa.size() < 2);
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL soak_in_ready cyc%0d: got %b want %b", cyc, in_ready, exp_rdy); end
      total++; if (outa_valid !== (qa.size() != 0) || (qa.size() != 0 && outa_data !== qa[0])) begin bad++; $display("FAIL soak_a cyc%0d: got v=%b d=%h want v=%b d=%h", cyc, outa_valid, outa_data, qa.size() != 0, (qa.size() != 0) ? qa[0] : 16'h0); end
      total++; if (outb_valid !== (qb.size() != 0) || (qb.size() != 0 && outb_data !== qb[0])) begin bad++; $display("FAIL soak_b cyc%0d: got v=%b d=%h want v=%b d=%h", cyc, outb_valid, outb_data, qb.size() != 0, (qb.size() != 0) ? qb[0] : 16'h0); end
      total++; if (cnt_a !== (CNT_ON ? 16'(pops_a) : 16'd0) || cnt_b !== (CNT_ON ? 16'(pops_b) : 16'd0)) begin bad++; $display("FAIL soak_cnt cyc%0d: got a=%0d b=%0d pops a=%0d b=%0d", cyc, cnt_a, cnt_b, pops_a, pops_b); end
      // flipping the consumer readies must not move in_ready
      outa_ready = ~ra; outb_ready = ~rb;
      #1;
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL soak_comb_path cyc%0d: got %b want %b", cyc, in_ready, exp_rdy); end
      outa_ready = ra; outb_ready = rb;
      do_push = in_valid && exp_rdy;
      do_pa   = (qa.size() != 0) && ra;
      do_pb   = (qb.size() != 0) && rb;
      @(posedge clk);
      if (do_pa) begin void'(qa.pop_front()); pops_a++; end
      if (do_pb) begin void'(qb.pop_front()); pops_b++; end
      if (do_push) begin
        if (in_sel) qb.push_back(in_data); else qa.push_back(in_data);
        sent++;
      end
      hold = in_valid && !exp_rdy;
      cyc++;
      @(negedge clk);
    end
    total++; if (sent != WORDS || qa.size() != 0 || qb.size() != 0 || pops_a + pops_b != WORDS) begin bad++; $display("FAIL soak_complete: got sent=%0d delivered=%0d left=%0d want %0d %0d 0", sent, pops_a + pops_b, qa.size() + qb.size(), WORDS, WORDS); end
    in_valid = 1'b0; outa_ready = 1'b0; outb_ready = 1'b0;
  endtask

`ifdef STREAM_DEMUX_CNT_EN
  task automatic test_cnt_wrap();
    do_reset();
    outa_ready = 1'b1; outb_ready = 1'b1;
    in_sel = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      in_data = 16'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++; if (cnt_a !== 16'd1 || cnt_b !== 16'd0) begin bad++; $display("FAIL cnt_wrap: got a=%0d b=%0d want 1 0", cnt_a, cnt_b); end
  endtask
`endif

  initial begin
    test_reset();
    test_routing();
    test_stall();
    test_push_pop_one();
    test_random_soak();
`ifdef STREAM_DEMUX_CNT_EN
    test_cnt_wrap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
